// File: rtl/gamecntl_seq.sv
// Game-control sequencer: debounced coin/start, credit counter, C9/D9 one-shot triggers.
// Optional free-play build: define GAMECNTL_FREE_PLAY_EN.
module gamecntl_seq #(
    parameter int DEB_CYCLES  = 16,
    parameter int TRG_WIDTH   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_CREDITS = 9,
    parameter int CREDIT_BW   = 4
) (
    input  logic                 CLK_DRV,
    input  logic                 RST_N,
    input  logic                 COIN_N,
    input  logic                 START_N,
    input  logic                 C9_OUT,
    input  logic                 D9_OUT,
    output logic                 TRG_C9_N,
    output logic                 TRG_D9_N,
    output logic                 GAME_ON,
    output logic                 ATTRACT_N,
    output logic [CREDIT_BW-1:0] CREDITS,
    output logic                 ERR
);

    localparam int DCW  = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (ACK_TIMEOUT > TRG_WIDTH) ? ACK_TIMEOUT : TRG_WIDTH;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ATTRACT, TRIG_C9, WAIT_ACK, PLAY, TRIG_D9, END_HOLD
    } state_t;

    // Bit 0 is the coin switch, bit 1 the start button.
    logic [1:0]     sw_raw;
    logic [1:0]     sync1_q, sync2_q, deb_q, evt_q;
    logic [DCW-1:0] cnt_q [2];
    logic           coin_evt, start_evt;

    assign sw_raw    = {START_N, COIN_N};
    assign coin_evt  = evt_q[0];
    assign start_evt = evt_q[1];

    always_ff @(posedge CLK_DRV or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            evt_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            for (int unsigned i = 0; i < 2; i++) begin
                evt_q[i] <= 1'b0;
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                        evt_q[i] <= ~sync2_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    logic                 c9_q, c9_prev_q, d9_q;
    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 seen_q, seen_d;
    logic                 err_q, err_d;
    logic [CREDIT_BW-1:0] credits_q, credits_d;
    logic                 accept, refund, can_start;

`ifdef GAMECNTL_FREE_PLAY_EN
    logic unused_fp;
    assign unused_fp = coin_evt ^ refund ^ accept;
    assign can_start = 1'b1;
    always_comb credits_d = CREDIT_BW'(MAX_CREDITS);
`else
    assign can_start = (credits_q != '0);
    always_comb begin
        credits_d = credits_q;
        if (accept) credits_d = credits_d - 1'b1;
        if (coin_evt && credits_d != CREDIT_BW'(MAX_CREDITS)) credits_d = credits_d + 1'b1;
        if (refund && credits_d != CREDIT_BW'(MAX_CREDITS)) credits_d = credits_d + 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        seen_d  = seen_q;
        err_d   = err_q;
        accept  = 1'b0;
        refund  = 1'b0;
        case (state_q)
            ATTRACT: begin
                if (start_evt && can_start) begin
                    accept  = 1'b1;
                    state_d = TRIG_C9;
                end
            end
            TRIG_C9: begin
                if (tmr_q == TW'(TRG_WIDTH - 1)) state_d = WAIT_ACK;
                else tmr_d = tmr_q + 1'b1;
            end
            WAIT_ACK: begin
                if (c9_q) begin
                    state_d = PLAY;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    refund  = 1'b1;
                    state_d = ATTRACT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            PLAY: begin
                if (c9_prev_q && !c9_q) state_d = TRIG_D9;
            end
            TRIG_D9: begin
                seen_d = 1'b0;
                if (tmr_q == TW'(TRG_WIDTH - 1)) state_d = END_HOLD;
                else tmr_d = tmr_q + 1'b1;
            end
            END_HOLD: begin
                // First wait for the fuel-bar timer to fire, then for it to expire.
                if (!seen_q) begin
                    if (d9_q) begin
                        seen_d = 1'b1;
                    end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ATTRACT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else if (!d9_q) begin
                    state_d = ATTRACT;
                end
            end
            default: state_d = ATTRACT;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge CLK_DRV or negedge RST_N) begin
        if (!RST_N) begin
            c9_q      <= 1'b0;
            c9_prev_q <= 1'b0;
            d9_q      <= 1'b0;
            state_q   <= ATTRACT;
            tmr_q     <= '0;
            seen_q    <= 1'b0;
            err_q     <= 1'b0;
            credits_q <= '0;
            TRG_C9_N  <= 1'b1;
            TRG_D9_N  <= 1'b1;
            GAME_ON   <= 1'b0;
            ATTRACT_N <= 1'b0;
        end else begin
            c9_q      <= C9_OUT;
            c9_prev_q <= c9_q;
            d9_q      <= D9_OUT;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            seen_q    <= seen_d;
            err_q     <= err_d;
            credits_q <= credits_d;
            TRG_C9_N  <= (state_d != TRIG_C9);
            TRG_D9_N  <= (state_d != TRIG_D9);
            GAME_ON   <= (state_d == TRIG_C9) || (state_d == WAIT_ACK) || (state_d == PLAY);
            ATTRACT_N <= (state_d != ATTRACT);
        end
    end

    assign CREDITS = credits_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_gamecntl_seq.sv
// Scoreboard bench for gamecntl_seq: stimulus pushes expected credit values and trigger
// pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_gamecntl_seq;
    localparam int DEB = 4, TWD = 4, ACK = 16, MAXC = 9, CBW = 4;

    logic clk = 1'b0, rst_n = 1'b0, coin_n = 1'b1, start_n = 1'b1, c9 = 1'b0, d9 = 1'b0;
    logic trg_c9_n, trg_d9_n, game_on, attract_n, err;
    logic [CBW-1:0] credits;

    always #5 clk = ~clk;

    gamecntl_seq #(.DEB_CYCLES(DEB), .TRG_WIDTH(TWD), .ACK_TIMEOUT(ACK),
                   .MAX_CREDITS(MAXC), .CREDIT_BW(CBW)) dut (
        .CLK_DRV(clk), .RST_N(rst_n), .COIN_N(coin_n), .START_N(start_n),
        .C9_OUT(c9), .D9_OUT(d9), .TRG_C9_N(trg_c9_n), .TRG_D9_N(trg_d9_n),
        .GAME_ON(game_on), .ATTRACT_N(attract_n), .CREDITS(credits), .ERR(err));

    int total = 0, bad = 0;
    int model_cr = 0;
    int exp_cr_q[$];
    int exp_pulse_q[$];   // 1000+width for C9, 2000+width for D9

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: credit changes, trigger pulse widths, trigger exclusivity.
    int last_cr = 0, c9w = 0, d9w = 0, e = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(credits) != last_cr) begin
                total++;
                if (exp_cr_q.size() == 0) begin
                    bad++;
                    $display("FAIL credits_change: got %0d expected no change from %0d", credits, last_cr);
                end else begin
                    e = exp_cr_q.pop_front();
                    if (int'(credits) != e) begin
                        bad++;
                        $display("FAIL credits_value: got %0d expected %0d", credits, e);
                    end
                end
                last_cr = int'(credits);
            end
            if (!trg_c9_n) c9w++;
            else if (c9w > 0) begin
                total++;
                e = (exp_pulse_q.size() > 0) ? exp_pulse_q.pop_front() : -1;
                if (e != 1000 + c9w) begin
                    bad++;
                    $display("FAIL c9_pulse: got %0d expected %0d", 1000 + c9w, e);
                end
                c9w = 0;
            end
            if (!trg_d9_n) d9w++;
            else if (d9w > 0) begin
                total++;
                e = (exp_pulse_q.size() > 0) ? exp_pulse_q.pop_front() : -1;
                if (e != 2000 + d9w) begin
                    bad++;
                    $display("FAIL d9_pulse: got %0d expected %0d", 2000 + d9w, e);
                end
                d9w = 0;
            end
            total++;
            if (!trg_c9_n && !trg_d9_n) begin
                bad++;
                $display("FAIL trg_exclusive: got both low expected at most one low");
            end
        end else begin
            last_cr = int'(credits);
            c9w = 0;
            d9w = 0;
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: return trg_c9_n;
            1: return trg_d9_n;
            2: return game_on;
            3: return attract_n;
            default: return err;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sig(input int sel, input logic lvl, input int bound,
                            input string name, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s: got no response expected within %0d cycles", name, bound);
        end
    endtask

    task automatic press(input bit coin, input bit start, input int hold);
        @(negedge clk);
        if (coin) coin_n = 1'b0;
        if (start) start_n = 1'b0;
        cyc(hold);
        coin_n = 1'b1;
        start_n = 1'b1;
        cyc(DEB + 4);
    endtask

    task automatic do_coin();
        int n;
        n = (model_cr < MAXC) ? model_cr + 1 : model_cr;
        if (n != model_cr) exp_cr_q.push_back(n);
        model_cr = n;
        press(1'b1, 1'b0, 8);
    endtask

    task automatic run_game(input int play_len, input bit extra);
        int n;
        bit ok;
        exp_pulse_q.push_back(1000 + TWD);
        model_cr--;
        exp_cr_q.push_back(model_cr);
        @(negedge clk);
        start_n = 1'b0;
        wait_sig(0, 1'b0, 20, "trg_c9_fall", n);
        check("game_on_trig", game_on, 1);
        check("attract_n_trig", attract_n, 1);
        start_n = 1'b1;
        wait_sig(0, 1'b1, TWD + 2, "trg_c9_rise", n);
        cyc(3);
        c9 = 1'b1;
        if (extra) begin
            do_coin();                 // counted during play
            press(1'b0, 1'b1, 8);      // start ignored during play
            check("game_on_after_presses", game_on, 1);
        end
        ok = 1'b1;
        for (int i = 0; i < play_len; i++) begin
            cyc(1);
            if (!game_on) ok = 1'b0;
        end
        check("game_on_play", ok, 1);
        c9 = 1'b0;
        exp_pulse_q.push_back(2000 + TWD);
        wait_sig(1, 1'b0, 10, "trg_d9_fall", n);
        wait_sig(1, 1'b1, TWD + 2, "trg_d9_rise", n);
        cyc(2);
        d9 = 1'b1;
        cyc(20);
        d9 = 1'b0;
        wait_sig(3, 1'b0, 10, "attract_after_d9", n);
        check("err_after_game", err, 0);
        check("game_on_after_game", game_on, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;
        cyc(3);
        check("rst_trg_c9_n", trg_c9_n, 1);
        check("rst_trg_d9_n", trg_d9_n, 1);
        check("rst_game_on", game_on, 0);
        check("rst_attract_n", attract_n, 0);
        check("rst_credits", credits, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        cyc(3);

        // Bounce, then stable low: one coin event
        for (int i = 0; i < 10; i++) begin
            coin_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        coin_n = 1'b0;
        model_cr = 1;
        exp_cr_q.push_back(1);
        n = 0;
        while (credits != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < 6 || n > 8) begin
            bad++;
            $display("FAIL bounce_latency: got %0d expected 6..8", n);
        end
        cyc(10 - n);
        coin_n = 1'b1;
        cyc(12);
        check("bounce_credits", credits, 1);

        // Drain the credit so start with none can be tried
        run_game(40, 1'b0);
        check("credits_after_game0", credits, 0);
        @(negedge clk);
        start_n = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!trg_c9_n || attract_n) ok = 1'b0;
        end
        start_n = 1'b1;
        cyc(10);
        check("nocredit_ignored", ok, 1);

        // Full game with a coin and an ignored start during play
        do_coin();
        run_game(66, 1'b1);
        check("credits_after_game1", credits, model_cr);

        // Acknowledge timeout with refund
        do_coin();
        check("credits_before_timeout", credits, 2);
        exp_pulse_q.push_back(1000 + TWD);
        model_cr--;
        exp_cr_q.push_back(model_cr);
        @(negedge clk);
        start_n = 1'b0;
        wait_sig(0, 1'b0, 20, "to_trg_c9_fall", n);
        start_n = 1'b1;
        wait_sig(0, 1'b1, TWD + 2, "to_trg_c9_rise", n);
        model_cr++;
        exp_cr_q.push_back(model_cr);
        wait_sig(4, 1'b1, 30, "err_rise", n);
        check("ack_timeout_cycle", n, ACK);
        cyc(1);
        check("timeout_credits", credits, 2);
        check("timeout_attract_n", attract_n, 0);
        check("timeout_err", err, 1);

        // Saturation
        for (int i = 0; i < 12; i++) do_coin();
        check("sat_credits", credits, MAXC);

        // Coin and accepted start together at MAX_CREDITS
        exp_pulse_q.push_back(1000 + TWD);
        @(negedge clk);
        coin_n = 1'b0;
        start_n = 1'b0;
        wait_sig(0, 1'b0, 20, "sim_trg_c9_fall", n);
        cyc(2);
        check("sim_credits", credits, MAXC);
        coin_n = 1'b1;
        start_n = 1'b1;
        wait_sig(0, 1'b1, TWD + 2, "sim_trg_c9_rise", n);
        cyc(3);
        c9 = 1'b1;
        cyc(30);
        c9 = 1'b0;
        exp_pulse_q.push_back(2000 + TWD);
        wait_sig(1, 1'b0, 10, "rst_trg_d9_fall", n);

        // Asynchronous reset while the fuel-bar trigger is low
        #2 rst_n = 1'b0;
        #1;
        check("arst_trg_c9_n", trg_c9_n, 1);
        check("arst_trg_d9_n", trg_d9_n, 1);
        check("arst_game_on", game_on, 0);
        check("arst_attract_n", attract_n, 0);
        check("arst_credits", credits, 0);
        check("arst_err", err, 0);
        exp_pulse_q.delete();
        model_cr = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        // Randomized rounds against the credit model
        for (int r = 0; r < 4; r++) begin
            int nc;
            nc = $urandom_range(0, 2);
            for (int k = 0; k < nc; k++) do_coin();
            if (model_cr > 0) begin
                run_game($urandom_range(20, 60), 1'b0);
            end else begin
                @(negedge clk);
                start_n = 1'b0;
                ok = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    cyc(1);
                    if (!trg_c9_n) ok = 1'b0;
                end
                start_n = 1'b1;
                cyc(10);
                check("rand_nocredit", ok, 1);
            end
            cyc($urandom_range(1, 10));
            check("rand_credits", credits, model_cr);
        end

        cyc(5);
        check("cr_queue_empty", exp_cr_q.size(), 0);
        check("pulse_queue_empty", exp_pulse_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gamecntl_seq.md
Name: gamecntl_seq

Overview:
- Game-control sequencer that drives the playtime (C9) and fuel-bar (D9) 555-style one-shot timers and consumes their outputs.
- Debounces the coin and start switches, keeps the credit count, and issues active-low trigger pulses on TRG_C9_N and TRG_D9_N.
- Tracks game phase (attract, play, end hold) and sits between the cabinet switch inputs and the game-control timer block.

Parameters:
- DEB_CYCLES, 16: consecutive stable samples needed to accept a switch level change.
- TRG_WIDTH, 4: trigger pulse low width in CLK_DRV cycles (≥1).
- ACK_TIMEOUT, 64: cycles allowed for C9_OUT to rise after the C9 trigger ends.
- MAX_CREDITS, 9: credit saturation value.
- CREDIT_BW, 4: credit counter width; must satisfy MAX_CREDITS < 2**CREDIT_BW.

Ports:
- CLK_DRV  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- COIN_N  in  1  coin switch, active low, asynchronous to CLK_DRV.
- START_N  in  1  start button, active low, asynchronous to CLK_DRV.
- C9_OUT  in  1  playtime timer output, high while the game time runs.
- D9_OUT  in  1  fuel-bar timer output, high during the end hold.
- TRG_C9_N  out  1  playtime timer trigger, active low.
- TRG_D9_N  out  1  fuel-bar timer trigger, active low.
- GAME_ON  out  1  high in TRIG_C9, WAIT_ACK and PLAY.
- ATTRACT_N  out  1  low in ATTRACT.
- CREDITS  out  CREDIT_BW  current credit count.
- ERR  out  1  sticky flag: timer acknowledge timeout.

Behaviour:
- Reset values: TRG_C9_N=1, TRG_D9_N=1, GAME_ON=0, ATTRACT_N=0, CREDITS=0, ERR=0, state ATTRACT, debouncers at released (1).
- Reset is asynchronous: asserting RST_N mid-game aborts immediately to the above. Any trigger in progress is released in the same clock-free assertion.
- Switch inputs:
  - COIN_N and START_N each pass a 2-FF synchronizer, then a debounce counter.
  - Debounced level changes only after DEB_CYCLES consecutive samples differ from the current debounced level.
  - A press event is a 1-cycle pulse on a debounced 1→0 transition.
  - Input-to-event latency is 2+DEB_CYCLES cycles.
- Credits:
  - coin_evt increments CREDITS, saturating at MAX_CREDITS.
  - Accepted start decrements CREDITS.
  - Coin and accepted start in the same cycle: net unchanged, except at MAX_CREDITS, which ends at MAX_CREDITS-1+1 = MAX_CREDITS.
  - Coins are counted in every state.
- FSM states, one transition per clock:
  - ATTRACT: on start_evt with CREDITS>0, go to TRIG_C9 and decrement CREDITS. start_evt with CREDITS=0 is ignored.
  - TRIG_C9: TRG_C9_N=0 for exactly TRG_WIDTH cycles, then WAIT_ACK. It goes low on the cycle after the accepting edge.
  - WAIT_ACK: C9_OUT=1 goes to PLAY. If the counter reaches ACK_TIMEOUT first: set ERR, refund one credit (saturating), go to ATTRACT.
  - PLAY: C9_OUT falling (registered 1→0) goes to TRIG_D9. start_evt is ignored.
  - TRIG_D9: TRG_D9_N=0 for TRG_WIDTH cycles, then END_HOLD.
  - END_HOLD: wait for D9_OUT=1, then wait for D9_OUT=0, then go to ATTRACT. The same ACK_TIMEOUT applies to the rise; on timeout, set ERR and go to ATTRACT with no refund.
- Trigger exclusivity: TRG_C9_N and TRG_D9_N are never low simultaneously.
- Output registering: all outputs are registered and glitch-free.
- ERR: cleared only by reset.

Optional Feature:
- Macro: GAMECNTL_FREE_PLAY_EN.
- Defined:
  - The credit logic is compiled out, and CREDITS is held at MAX_CREDITS.
  - Any start_evt in ATTRACT starts a game.
  - Coins are ignored.
  - A WAIT_ACK timeout sets ERR only, with no refund.
- Undefined: the credit behaviour above applies.

Test Plan (bench uses DEB_CYCLES=4, TRG_WIDTH=4, ACK_TIMEOUT=16, MAX_CREDITS=9):
- Bounce check: COIN_N toggles low/high every 2 cycles for 20 cycles, then holds low 10 cycles -> exactly one increment, CREDITS=1, occurring 6 cycles after the stable low.
- Start with no credit: START_N pressed with CREDITS=0 -> TRG_C9_N stays 1 and state stays ATTRACT.
- Full game:
  - Stimulus: 1 coin, start; model raises C9_OUT 3 cycles after trigger and drops it 100 cycles later; D9_OUT high for 20 cycles.
  - Required: CREDITS 1→0; TRG_C9_N low 4 cycles; GAME_ON=1 through PLAY.
  - Required: TRG_D9_N low 4 cycles after C9_OUT falls; ATTRACT_N=0 after D9_OUT falls; ERR=0.
- Acknowledge timeout: 2 coins, start, C9_OUT held 0 -> ERR=1 at cycle 16 of WAIT_ACK, CREDITS returns to 2, state ATTRACT.
- Saturation and simultaneous events:
  - 12 coins -> CREDITS=9.
  - Coin event and accepted start in the same cycle at CREDITS=9 -> CREDITS=9.
- Reset mid-game: assert RST_N in PLAY while TRG_D9_N pending -> all outputs take reset values asynchronously before the next clock edge.
